johnson_seq_ctrl: RTL
=====================

Name: johnson_seq_ctrl

Overview:
- Run controller for a pipelined Johnson phase generator.
- Accepts a start command with a rotation count and steps an internal N-bit Johnson counter through 2N phases per rotation.
- Emits each phase through a STAGES-deep output pipeline with a valid qualifier; supports hold (stall) and abort.
- Signals completion with a done pulse. Sits between the sequencing/command logic and multiphase consumers (clock-enable slots, scan phases).

Parameters:
- N, 4, Johnson counter width; 2N phases per rotation; N>=2.
- STAGES, 2, output pipeline depth; STAGES>=1.
- CNT_W, 8, width of rotation count.
- PW (localparam), $clog2(2*N), width of phase_idx.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  command pulse; sampled only in IDLE.
- rotations  in  CNT_W  full rotations to run; sampled with start.
- hold  in  1  stall phase advance while RUN.
- abort  in  1  terminate run; honoured in RUN only.
- busy  out  1  high in RUN and DRAIN.
- phase_valid  out  1  phase_q/phase_idx/wrap valid this cycle.
- phase_q  out  N  pipelined Johnson state.
- phase_idx  out  PW  steps since 0 in current rotation, 0..2N-1.
- wrap  out  1  high with the beat where phase_idx==2N-1.
- done  out  1  one-cycle pulse at end of run.
- aborted  out  1  qualifies done; 1 if run ended by abort.

Behaviour:
- Reset: all outputs 0, Johnson state js=0, idx=0, FSM=IDLE, pipeline valids cleared. Reset mid-run discards everything; no done pulse.
- Johnson step: js <= {~js[0], js[N-1:1]}. Sequence for N=4: 0000,1000,1100,1110,1111,0111,0011,0001,0000. idx increments with each step and wraps 2N-1 -> 0 alongside js returning to 0.
- FSM IDLE:
  - start && rotations!=0: latch remaining=rotations, go to RUN.
  - start && rotations==0: ignored; no busy, no done.
- FSM RUN, each cycle, in priority order:
  - abort: js=0, idx=0, nothing emitted, set abort flag, go to DRAIN.
  - hold: no advance, bubble (valid=0) into stage 1.
  - else: emit {js, idx, wrap=(idx==2N-1)} with valid=1 into stage 1, then advance.
  - When the emitted idx==2N-1: decrement remaining. If remaining was 1, go to DRAIN with js=0, idx=0.
- FSM DRAIN: pipeline shifts for exactly STAGES cycles. Then done=1 (aborted=flag) for one cycle, clear flag, go to IDLE. start is ignored in RUN and DRAIN.
- Pipeline: free-running, never stalled by hold. Outputs are stage STAGES.
- Latency, start sampled at edge k, no hold or abort:
  - First beat (phase_q=0, idx=0) valid after edge k+STAGES.
  - Total valid beats = R*2N, contiguous.
  - Last beat is after edge k+R*2N+STAGES-1.
  - done is high after edge k+R*2N+STAGES.
- busy: rises after edge k, falls with the done cycle's edge (low the cycle after done).
- remaining width CNT_W; maximum run 2^CNT_W-1 rotations; no overflow possible.

Optional Feature:
- Macro JSC_ONEHOT_EN.
- Defined: adds output phase_onehot [2N-1:0]. It is a one-hot decode of idx, pipelined in lockstep with phase_q, and all-zero when phase_valid=0.
- Undefined: port and decode logic absent; all other behaviour identical.

Test Plan (N=4, STAGES=2, CNT_W=8):
- Reset, then start with rotations=1 at edge k -> 8 valid beats after edges k+2..k+9, phase_q 0000,1000,1100,1110,1111,0111,0011,0001, idx 0..7, wrap only on beat 8; done=1, aborted=0 after edge k+10; busy low after k+11.
- rotations=3 -> 24 contiguous valid beats, wrap on beats 8,16,24, exactly one done pulse.
- rotations=2, hold high for 3 cycles mid-run -> 3 phase_valid=0 bubbles, sequence resumes at the held phase with no skip/repeat, done delayed by 3 cycles.
- rotations=5, abort after 10 emitted beats -> no further valid beats after pipeline empties (10 total), done=1 with aborted=1; next start restarts at phase_q=0000.
- start with rotations=0 -> busy, phase_valid, done stay 0. start while busy -> ignored, beat count unchanged. Async reset mid-run -> all outputs 0 immediately, no done.
- JSC_ONEHOT_EN defined -> phase_onehot = 1<<idx on every valid beat, 0 on bubbles.

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// Run controller for a pipelined Johnson phase generator.
// A start command loads a rotation count. Each rotation steps an N-bit Johnson counter
// through 2N phases. Every phase is emitted through a STAGES-deep pipeline with a valid flag.
// The run can be stalled with hold or ended early with abort, and finishes with a done pulse.
// Optional macro JSC_ONEHOT_EN adds the phase_onehot output, a one-hot decode of phase_idx.
module johnson_seq_ctrl #(
   parameter int unsigned N      = 4,
   parameter int unsigned STAGES = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [CNT_W-1:0]          rotations,
   input  logic                      hold,
   input  logic                      abort,
   output logic                      busy,
   output logic                      phase_valid,
   output logic [N-1:0]              phase_q,
   output logic [$clog2(2*N)-1:0]    phase_idx,
   output logic                      wrap,
   output logic                      done,
   output logic                      aborted
`ifdef JSC_ONEHOT_EN
   ,
   output logic [2*N-1:0]            phase_onehot
`endif
);

   localparam int unsigned PW = $clog2(2*N);
   localparam int unsigned DW = $clog2(STAGES + 1);
   localparam logic [PW-1:0] LastIdx   = PW'(2*N - 1);
   localparam logic [DW-1:0] DrainLast = DW'(STAGES);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e           state_q, state_d;
   logic [N-1:0]     js_q, js_d;
   logic [PW-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             abort_flag_q, abort_flag_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic             emit_valid;
   logic             emit_wrap;

   // Output pipeline. Slot 0 is loaded from the FSM and slot STAGES-1 drives the outputs.
   logic             pv_q    [STAGES];
   logic [N-1:0]     pph_q   [STAGES];
   logic [PW-1:0]    pidx_q  [STAGES];
   logic             pwrap_q [STAGES];

`ifdef JSC_ONEHOT_EN
   localparam logic [2*N-1:0] OhOne = {{(2*N-1){1'b0}}, 1'b1};
   logic [2*N-1:0]   poh_q   [STAGES];
   logic [2*N-1:0]   oh_in;
`else
   // No one-hot decode in this build.
`endif

   // Control state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         js_q         <= '0;
         idx_q        <= '0;
         rem_q        <= '0;
         abort_flag_q <= 1'b0;
         drain_q      <= '0;
      end else begin
         state_q      <= state_d;
         js_q         <= js_d;
         idx_q        <= idx_d;
         rem_q        <= rem_d;
         abort_flag_q <= abort_flag_d;
         drain_q      <= drain_d;
      end
   end

   // Next-state logic: abort beats hold, hold beats phase advance
   always_comb begin
      state_d      = state_q;
      js_d         = js_q;
      idx_d        = idx_q;
      rem_d        = rem_q;
      abort_flag_d = abort_flag_q;
      drain_d      = drain_q;
      emit_valid   = 1'b0;
      emit_wrap    = (idx_q == LastIdx);
      unique case (state_q)
         StIdle: begin
            // A start with a zero count is dropped silently.
            if (start && (rotations != '0)) begin
               rem_d        = rotations;
               abort_flag_d = 1'b0;
               drain_d      = '0;
               state_d      = StRun;
            end
         end
         StRun: begin
            if (abort) begin
               js_d         = '0;
               idx_d        = '0;
               abort_flag_d = 1'b1;
               drain_d      = '0;
               state_d      = StDrain;
            end else if (!hold) begin
               emit_valid = 1'b1;
               js_d       = {~js_q[0], js_q[N-1:1]};
               idx_d      = emit_wrap ? '0 : idx_q + 1'b1;
               if (emit_wrap) begin
                  rem_d = rem_q - 1'b1;
                  if (rem_q == CNT_W'(1)) begin
                     js_d    = '0;
                     idx_d   = '0;
                     drain_d = '0;
                     state_d = StDrain;
                  end
               end
            end
         end
         StDrain: begin
            // STAGES shift cycles empty the pipeline, then one extra cycle carries done.
            if (drain_q == DrainLast) begin
               abort_flag_d = 1'b0;
               drain_d      = '0;
               state_d      = StIdle;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef JSC_ONEHOT_EN
   // One-hot decode of the emitted index, zero on bubbles
   always_comb begin
      oh_in = '0;
      if (emit_valid) begin
         oh_in = OhOne << idx_q;
      end
   end
`endif

   // Free-running output pipeline; bubbles carry zero data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < STAGES; s++) begin
            pv_q[s]    <= 1'b0;
            pph_q[s]   <= '0;
            pidx_q[s]  <= '0;
            pwrap_q[s] <= 1'b0;
`ifdef JSC_ONEHOT_EN
            poh_q[s]   <= '0;
`endif
         end
      end else begin
         pv_q[0]    <= emit_valid;
         pph_q[0]   <= emit_valid ? js_q : '0;
         pidx_q[0]  <= emit_valid ? idx_q : '0;
         pwrap_q[0] <= emit_valid & emit_wrap;
`ifdef JSC_ONEHOT_EN
         poh_q[0]   <= oh_in;
`endif
         for (int s = 1; s < STAGES; s++) begin
            pv_q[s]    <= pv_q[s-1];
            pph_q[s]   <= pph_q[s-1];
            pidx_q[s]  <= pidx_q[s-1];
            pwrap_q[s] <= pwrap_q[s-1];
`ifdef JSC_ONEHOT_EN
            poh_q[s]   <= poh_q[s-1];
`endif
         end
      end
   end

   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDrain) && (drain_q == DrainLast);
   assign aborted     = done & abort_flag_q;
   assign phase_valid = pv_q[STAGES-1];
   assign phase_q     = pph_q[STAGES-1];
   assign phase_idx   = pidx_q[STAGES-1];
   assign wrap        = pwrap_q[STAGES-1];
`ifdef JSC_ONEHOT_EN
   assign phase_onehot = poh_q[STAGES-1];
`endif

endmodule
